uart_tx_cfg: RTL and testbench

//  Parametrised UART transmit engine: control FSM, serializer, parity generator and output mux in one block.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_serializer.sv | 64 ++++++
 rtl/uart_tx_cfg.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit engine.
//   - uart_state_e : control FSM state encodings
//   - PAR_EVEN / PAR_ODD : values of the par_typ configuration input
//   - DW_MIN / DW_MAX : legal range for the DATA_WIDTH parameter
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DW_MIN = 5;
    localparam int DW_MAX = 16;

endpackage

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//   Data path of the UART transmitter: shadow shift register holding the
//   word being sent, the data-bit counter and the parity bit.
//   Ports:
//     clk, reset   clock, async active-low reset
//     load         latch p_data and compute parity (frame accept)
//     first        START->DATA step: consume bit 0, bit_cnt = 0
//     shift        DATA step: consume next bit, bit_cnt + 1
//     p_data       parallel word (sampled on load)
//     par_typ      parity type (sampled on load)
//     cur_bit      next data bit to drive onto the line
//     par_bit      parity bit of the latched word
//     ser_done     bit_cnt is on the last data bit
// ---------------------------------------------------------------------------
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  first,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  par_typ,
    output logic                  cur_bit,
    output logic                  par_bit,
    output logic                  ser_done
);

    localparam int CW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] sh_q;
    logic [CW-1:0]         bit_cnt;
    logic                  par_q;

    // sh_q[0] is always the next bit to go out: it holds D0 until the
    // START->DATA step and is shifted once per data bit after that.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q    <= '0;
            bit_cnt <= '0;
            par_q   <= 1'b0;
        end else if (load) begin
            sh_q    <= p_data;
            bit_cnt <= '0;
            // Odd parity is the inverse of the XOR reduction.
            par_q   <= (^p_data) ^ (par_typ == PAR_ODD);
        end else if (first) begin
            sh_q    <= sh_q >> 1;
            bit_cnt <= '0;
        end else if (shift) begin
            sh_q    <= sh_q >> 1;
            bit_cnt <= bit_cnt + CW'(1);
        end
    end

    assign cur_bit  = sh_q[0];
    assign par_bit  = par_q;
    assign ser_done = (bit_cnt == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg
//   UART transmit engine. One frame per accepted word: start bit,
//   DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits.
//   Every bit boundary is aligned to baud_tick. Frames run back-to-back
//   when a new word is accepted during the final stop bit.
//   Ports:
//     clk, reset   clock, async active-low reset
//     baud_tick    one-clk pulse per bit period
//     p_data       word to send, held with data_valid until data_ack
//     data_valid   word available
//     par_en       1 = parity bit present
//     par_typ      0 = even, 1 = odd parity
//     stop2        1 = two stop bits
//     tx_out       registered serial line, idles high
//     busy         registered, high while a frame is on the line
//     data_ack     one-clk pulse after the edge that accepted the word
// ---------------------------------------------------------------------------
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  baud_tick,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop2,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  data_ack
);

    if (DATA_WIDTH < DW_MIN || DATA_WIDTH > DW_MAX) begin : g_bad_width
        $error("uart_tx_cfg: DATA_WIDTH outside legal range");
    end

    uart_state_e state, state_n;
    logic        tx_n, busy_n, ack_n;
    logic        stop_cnt, stop_cnt_n;
    logic        par_en_q, stop2_q;
    logic        load, first, shift;
    logic        cur_bit, par_bit, ser_done;
    logic        accept, last_stop;

    assign accept    = data_valid & baud_tick;
    // stop_cnt runs 0 (one stop bit) or 0,1 (two stop bits).
    assign last_stop = (stop_cnt == stop2_q);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .first    (first),
        .shift    (shift),
        .p_data   (p_data),
        .par_typ  (par_typ),
        .cur_bit  (cur_bit),
        .par_bit  (par_bit),
        .ser_done (ser_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            data_ack <= 1'b0;
            stop_cnt <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
        end else begin
            state    <= state_n;
            tx_out   <= tx_n;
            busy     <= busy_n;
            data_ack <= ack_n;
            stop_cnt <= stop_cnt_n;
            if (load) begin
                par_en_q <= par_en;
                stop2_q  <= stop2;
            end
        end
    end

    always_comb begin
        state_n    = state;
        tx_n       = tx_out;
        busy_n     = busy;
        ack_n      = 1'b0;
        stop_cnt_n = stop_cnt;
        load       = 1'b0;
        first      = 1'b0;
        shift      = 1'b0;

        case (state)
            ST_IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (accept) begin
                    load    = 1'b1;
                    ack_n   = 1'b1;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    first   = 1'b1;
                    tx_n    = cur_bit;
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (!ser_done) begin
                        shift = 1'b1;
                        tx_n  = cur_bit;
                    end else if (par_en_q) begin
                        tx_n    = par_bit;
                        state_n = ST_PARITY;
                    end else begin
                        tx_n       = 1'b1;
                        stop_cnt_n = 1'b0;
                        state_n    = ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    tx_n       = 1'b1;
                    stop_cnt_n = 1'b0;
                    state_n    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (!last_stop) begin
                        stop_cnt_n = 1'b1;
                    end else if (data_valid) begin
                        // Next start bit follows the last stop bit directly.
                        load    = 1'b1;
                        ack_n   = 1'b1;
                        tx_n    = 1'b0;
                        state_n = ST_START;
                    end else begin
                        busy_n  = 1'b0;
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n    = ST_IDLE;
                tx_n       = 1'b1;
                busy_n     = 1'b0;
                stop_cnt_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_cfg
//   Self-checking bench for uart_tx_cfg (DATA_WIDTH = 8, baud_tick every
//   16 clk). Expected line bits come from a frame model built as a bit
//   list: start 0, data LSB first, optional parity, 1 or 2 stop bits.
// ---------------------------------------------------------------------------
module tb_uart_tx_cfg;

    localparam int DW       = 8;
    localparam int TICK_DIV = 16;

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic          baud_tick  = 1'b0;
    logic [DW-1:0] p_data     = '0;
    logic          data_valid = 1'b0;
    logic          par_en     = 1'b0;
    logic          par_typ    = 1'b0;
    logic          stop2      = 1'b0;
    logic          tx_out, busy, data_ack;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_cnt = 0;
    int busy_ticks;
    bit exp_q[$];
    bit obs_q[$];

    typedef struct {
        logic [DW-1:0] w;
        bit            pe;
        bit            pt;
        bit            s2;
        int            len;
        bit            par;
    } vec_t;

    vec_t vecs[4];

    uart_tx_cfg #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_tick  (baud_tick),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .stop2      (stop2),
        .tx_out     (tx_out),
        .busy       (busy),
        .data_ack   (data_ack)
    );

    always #5 clk = ~clk;

    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            div       = (div == TICK_DIV - 1) ? 0 : div + 1;
            baud_tick = (div == TICK_DIV - 1);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (data_ack === 1'b1) ack_cnt++;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Returns #1 after the next clk edge that sees baud_tick high.
    task automatic tick();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 4 * TICK_DIV; k++) begin
            @(posedge clk);
            if (baud_tick) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) check("tick_timeout", 0, 1);
    endtask

    task automatic mk_frame(input logic [DW-1:0] w, input bit pe, input bit pt, input bit s2);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(w[i]);
        if (pe) exp_q.push_back(pt ? ~(^w) : ^w);
        exp_q.push_back(1'b1);
        if (s2) exp_q.push_back(1'b1);
    endtask

    task automatic start_frame(input logic [DW-1:0] w, input bit pe, input bit pt, input bit s2);
        mk_frame(w, pe, pt, s2);
        @(negedge clk);
        p_data = w; par_en = pe; par_typ = pt; stop2 = s2;
        data_valid = 1'b1;
        tick();
        check("accept_ack", data_ack, 1);
        data_valid = 1'b0;
    endtask

    // Called just after the accept edge; follows the frame through its last
    // stop bit. At bit index scr the inputs are toggled to prove they were
    // sampled only at accept.
    task automatic frame_body(input int scr);
        obs_q.delete();
        check("start_bit", tx_out, 0);
        check("start_busy", busy, 1);
        obs_q.push_back(tx_out);
        busy_ticks = busy ? 1 : 0;
        @(posedge clk); #1;
        check("ack_pulse_width", data_ack, 0);
        for (int i = 1; i < exp_q.size(); i++) begin
            tick();
            if (i == scr) begin
                p_data = ~p_data; par_en = ~par_en; par_typ = ~par_typ; stop2 = ~stop2;
            end
            obs_q.push_back(tx_out);
            if (busy) busy_ticks++;
            check($sformatf("bit%0d", i), tx_out, exp_q[i]);
            check($sformatf("busy%0d", i), busy, 1);
        end
    endtask

    task automatic finish_idle();
        tick();
        check("end_busy", busy, 0);
        check("end_line", tx_out, 1);
        check("frame_len", busy_ticks, exp_q.size());
    endtask

    initial begin
        int a0;
        logic [9:0] pat;
        logic [9:0] pat_a5;
        logic [DW-1:0] w;

        vecs[0] = '{w: 8'hA5, pe: 0, pt: 0, s2: 0, len: 10, par: 0};
        vecs[1] = '{w: 8'h07, pe: 1, pt: 0, s2: 0, len: 11, par: 1};
        vecs[2] = '{w: 8'h07, pe: 1, pt: 1, s2: 0, len: 11, par: 0};
        vecs[3] = '{w: 8'h00, pe: 1, pt: 0, s2: 1, len: 12, par: 0};
        pat_a5 = 10'b11_0100_1010;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx_out, 1);
        check("rst_busy", busy, 0);
        check("rst_ack", data_ack, 0);
        @(negedge clk);
        reset = 1'b1;

        // Directed table
        for (int v = 0; v < 4; v++) begin
            a0 = ack_cnt;
            start_frame(vecs[v].w, vecs[v].pe, vecs[v].pt, vecs[v].s2);
            frame_body(3);
            finish_idle();
            check($sformatf("vec%0d_len", v), busy_ticks, vecs[v].len);
            if (vecs[v].pe) check($sformatf("vec%0d_par", v), obs_q[1 + DW], vecs[v].par);
            check($sformatf("vec%0d_acks", v), ack_cnt - a0, 1);
            if (v == 0) begin
                for (int i = 0; i < 10; i++) pat[i] = obs_q[i];
                check("a5_pattern", pat, pat_a5);
            end
        end

        // Config toggled mid-frame, next frame uses the new values
        start_frame(8'h5A, 0, 0, 0);
        frame_body(3);
        finish_idle();
        check("cfg_hold_len", busy_ticks, 10);
        start_frame(8'h5A, 1, 1, 1);
        frame_body(-1);
        finish_idle();
        check("cfg_new_len", busy_ticks, 12);
        check("cfg_new_par", obs_q[1 + DW], 1);

        // Back-to-back words with data_valid held
        a0 = ack_cnt;
        mk_frame(8'h55, 0, 0, 0);
        @(negedge clk);
        p_data = 8'h55; par_en = 0; par_typ = 0; stop2 = 0;
        data_valid = 1'b1;
        tick();
        check("b2b_ack0", data_ack, 1);
        p_data = 8'h0F;
        frame_body(-1);
        mk_frame(8'h0F, 0, 0, 0);
        tick();
        check("b2b_ack1", data_ack, 1);
        data_valid = 1'b0;
        frame_body(-1);
        finish_idle();
        check("b2b_acks", ack_cnt - a0, 2);

        // data_valid without tick, then withdrawn before any tick
        tick();
        a0 = ack_cnt;
        @(negedge clk);
        p_data = 8'hC3; data_valid = 1'b1;
        @(posedge clk); #1;
        check("no_tick_ack", data_ack, 0);
        check("no_tick_busy", busy, 0);
        @(negedge clk);
        data_valid = 1'b0;
        tick();
        tick();
        check("withdrawn_busy", busy, 0);
        check("withdrawn_line", tx_out, 1);
        check("withdrawn_acks", ack_cnt - a0, 0);

        // Reset during the 4th data bit
        start_frame(8'h99, 0, 0, 0);
        repeat (4) tick();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_tx", tx_out, 1);
        check("midrst_busy", busy, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("postrst_tx", tx_out, 1);
        check("postrst_busy", busy, 0);
        start_frame(8'h3C, 0, 0, 0);
        frame_body(-1);
        finish_idle();

        // Randomized frames against the frame model
        for (int r = 0; r < 12; r++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            w = DW'($urandom);
            start_frame(w, 1'($urandom), 1'($urandom), 1'($urandom));
            frame_body(int'($urandom_range(1, 8)));
            finish_idle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
